rand_synch_hold_checker: RTL

RAND_SYNCH_HOLD_CHECKER -- requirements
Module: rand_synch_hold_checker

---
 rtl/rand_synch_hold_checker.sv | 97 +++++++++
 1 files changed

// File: rtl/rand_synch_hold_checker.sv
// rand_synch_hold_checker: drives random hold/free phases to a holdable source and flags data changes during hold.
// Define RAND_SYNCH_HOLD_CHECKER_CNT_EN to build the change/violation counters; otherwise they read 0.
module rand_synch_hold_checker #(
  parameter int          DATA_WIDTH      = 8,
  parameter int          MIN_HOLD_CYCLES = 1,
  parameter int          MAX_HOLD_CYCLES = 4,
  parameter int          MIN_FREE_CYCLES = 1,
  parameter int          MAX_FREE_CYCLES = 4,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  hold_o,
  output logic                  violation_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  change_cnt_o,
  output logic [CNT_WIDTH-1:0]  viol_cnt_o
);
  if (MIN_HOLD_CYCLES < 1 || MAX_HOLD_CYCLES < MIN_HOLD_CYCLES || MIN_FREE_CYCLES < 0 ||
      MAX_FREE_CYCLES < MIN_FREE_CYCLES || LFSR_SEED == 32'h0) begin : g_bad_params
    $fatal(1, "rand_synch_hold_checker: illegal parameter set");
  end
  localparam int RH   = MAX_HOLD_CYCLES - MIN_HOLD_CYCLES + 1;
  localparam int RF   = MAX_FREE_CYCLES - MIN_FREE_CYCLES + 1;
  localparam int MAXL = MAX_HOLD_CYCLES > MAX_FREE_CYCLES ? MAX_HOLD_CYCLES : MAX_FREE_CYCLES;
  localparam int LW   = $clog2(MAXL + 1);
  typedef enum logic [1:0] {IDLE, FREE, HOLD} state_t;
  state_t                state_q, state_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q, diff, viol_det;
  int                    draw_h, draw_f, len_f;
  assign lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign draw_h   = MIN_HOLD_CYCLES + int'({16'h0, lfsr_q[15:0]}) % RH;
  assign draw_f   = MIN_FREE_CYCLES + int'({16'h0, lfsr_q[15:0]}) % RF;
  assign len_f    = draw_f < 1 ? 1 : draw_f;
  assign diff     = data_valid_q && (data_i != data_q);
  assign viol_det = hold_o && diff;
  // rem counts the cycles left in the current phase after this one
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!en_i) state_d = IDLE;
    else if (state_q == IDLE) begin
      state_d = FREE;
      rem_d   = LW'(len_f - 1);
    end else if (rem_q != '0) rem_d = rem_q - LW'(1);
    else if (state_q == FREE) begin
      state_d = HOLD;
      rem_d   = LW'(draw_h - 1);
    end else begin
      state_d = FREE;
      rem_d   = LW'(len_f - 1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      hold_o       <= 1'b0;
      violation_o  <= 1'b0;
      err_o        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      hold_o       <= state_d == HOLD;
      violation_o  <= viol_det;
      err_o        <= err_o | viol_det;
      lfsr_q       <= en_i ? lfsr_d : lfsr_q;
      data_valid_q <= en_i;
    end
  end
  always_ff @(posedge clk_i) data_q <= data_i;
`ifdef RAND_SYNCH_HOLD_CHECKER_CNT_EN
  logic [CNT_WIDTH-1:0] chg_q, vcnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chg_q  <= '0;
      vcnt_q <= '0;
    end else begin
      chg_q  <= (diff && !(&chg_q)) ? chg_q + CNT_WIDTH'(1) : chg_q;
      vcnt_q <= (viol_det && !(&vcnt_q)) ? vcnt_q + CNT_WIDTH'(1) : vcnt_q;
    end
  end
  assign change_cnt_o = chg_q;
  assign viol_cnt_o   = vcnt_q;
`else
  assign change_cnt_o = '0;
  assign viol_cnt_o   = '0;
`endif
endmodule
